// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control sequencer.
//   - state_t     : sequencer phases FETCH/DECODE/EXEC/MEM/WB/TRAP
//   - op_class_t  : decoded instruction class registered at DECODE
//   - imm_sel_t   : immediate format selector for imm_gen
//   - opcode, funct, ALU control and trap cause constants
package ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {CLS_R, CLS_ADDI, CLS_LD, CLS_SD, CLS_BEQ, CLS_ILL} op_class_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} imm_sel_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control sequencer and the datapath.
//   Instruction/alu_zero/mem_ready flow into the sequencer; all control
//   enables, Imm, trap status and the retired count flow out of it.
//   master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(parameter int BITS = 64);

  logic [31:0]     Instruction;
  logic            alu_zero;
  logic            mem_ready;
  logic            pc_write_en;
  logic [1:0]      ALUControl;
  logic            RegWrite;
  logic            MemWrite;
  logic            Branch;
  logic            MemToReg;
  logic            ALUScr;
  logic [BITS-1:0] Imm;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [31:0]     retired;

  modport master (
    input  Instruction, alu_zero, mem_ready,
    output pc_write_en, ALUControl, RegWrite, MemWrite, Branch, MemToReg,
           ALUScr, Imm, trap, trap_cause, retired
  );

  modport slave (
    output Instruction, alu_zero, mem_ready,
    input  pc_write_en, ALUControl, RegWrite, MemWrite, Branch, MemToReg,
           ALUScr, Imm, trap, trap_cause, retired
  );

endinterface

// File: rtl/multicycle_ctrl_imm_gen.sv
// imm_gen: purely combinational immediate extraction for I, S and B formats,
// sign-extended to BITS.
//   instr : 32-bit instruction word
//   sel   : format select (IMM_I / IMM_S / IMM_B)
//   imm   : sign-extended immediate
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        sel,
  output logic [BITS-1:0] imm
);

  // Opcode/funct3/rs1 fields never contribute to an immediate.
  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  // B-format scatters the offset bits and always has an implicit zero LSB.
  always_comb begin
    imm = '0;
    case (sel)
      IMM_S:   imm = {{(BITS-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(BITS-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      default: imm = {{(BITS-12){instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the 64-bit RISC-V datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, stretches MEM until mem_ready, and traps on
// illegal instructions or a memory timeout (TRAP is left only through rst).
//   clk, rst    : clock and synchronous active-high reset
//   bus.master  : Instruction, alu_zero, mem_ready in; pc_write_en, ALUControl,
//                 RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm, trap,
//                 trap_cause, retired out
// Optional feature macro: PERF_CNT_EN (retired-instruction counter);
// when undefined, retired is tied to 0.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int BITS        = 64,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [31:0]     ir_q;
  op_class_t       cls_q, dec_cls;
  logic [1:0]      alu_q, dec_alu;
  logic            src_q, dec_src;
  imm_sel_t        dec_sel;
  logic [BITS-1:0] imm_q, imm_w;
  logic [CW-1:0]   cnt_q;
  logic            timed_out;
  logic            trap_q;
  logic [1:0]      cause_q;

  logic pcw, reg_write, mem_write, branch, mem_to_reg;

  // Branch resolution lives in the datapath, so the zero flag is not needed here.
  logic unused_zero;
  assign unused_zero = bus.alu_zero;

  imm_gen #(.BITS(BITS)) u_imm_gen (
    .instr (ir_q),
    .sel   (dec_sel),
    .imm   (imm_w)
  );

  // Instruction decode from the IR; the result is only captured in DECODE.
  always_comb begin
    dec_cls = CLS_ILL;
    dec_alu = ALU_ADD;
    dec_src = 1'b0;
    dec_sel = IMM_I;
    case (ir_q[6:0])
      OP_R: begin
        if (ir_q[14:12] == F3_ADD_SUB && ir_q[31:25] == F7_BASE) begin
          dec_cls = CLS_R;
          dec_alu = ALU_ADD;
        end else if (ir_q[14:12] == F3_ADD_SUB && ir_q[31:25] == F7_ALT) begin
          dec_cls = CLS_R;
          dec_alu = ALU_SUB;
        end else if (ir_q[14:12] == F3_AND && ir_q[31:25] == F7_BASE) begin
          dec_cls = CLS_R;
          dec_alu = ALU_AND;
        end else if (ir_q[14:12] == F3_OR && ir_q[31:25] == F7_BASE) begin
          dec_cls = CLS_R;
          dec_alu = ALU_OR;
        end
      end
      OP_IMM: begin
        if (ir_q[14:12] == F3_ADD_SUB) begin
          dec_cls = CLS_ADDI;
          dec_src = 1'b1;
        end
      end
      OP_LOAD: begin
        if (ir_q[14:12] == F3_DOUBLE) begin
          dec_cls = CLS_LD;
          dec_src = 1'b1;
        end
      end
      OP_STORE: begin
        if (ir_q[14:12] == F3_DOUBLE) begin
          dec_cls = CLS_SD;
          dec_src = 1'b1;
          dec_sel = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (ir_q[14:12] == F3_BEQ) begin
          dec_cls = CLS_BEQ;
          dec_alu = ALU_SUB;
          dec_sel = IMM_B;
        end
      end
      default: dec_cls = CLS_ILL;
    endcase
  end

  // The timeout is judged on the wait count alone, so a late mem_ready in the
  // timeout cycle does not rescue the access.
  assign timed_out = (cnt_q == TIMEOUT_VAL);

  // Next-state and enable decode. Only MEM looks at mem_ready, and only to
  // decide pc_write_en for stores and where to go next.
  always_comb begin
    state_d    = state_q;
    pcw        = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = (dec_cls == CLS_ILL) ? TRAP : EXEC;
      EXEC: begin
        case (cls_q)
          CLS_BEQ: begin
            branch  = 1'b1;
            pcw     = 1'b1;
            state_d = FETCH;
          end
          CLS_LD, CLS_SD: state_d = MEM;
          default:        state_d = WB;
        endcase
      end
      MEM: begin
        mem_write  = (cls_q == CLS_SD) && !timed_out;
        mem_to_reg = (cls_q == CLS_LD);
        if (timed_out) begin
          state_d = TRAP;
        end else if (bus.mem_ready) begin
          if (cls_q == CLS_SD) begin
            pcw     = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pcw        = 1'b1;
        mem_to_reg = (cls_q == CLS_LD);
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // State, IR, decoded controls, wait counter and sticky trap status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      cls_q   <= CLS_R;
      alu_q   <= ALU_ADD;
      src_q   <= 1'b0;
      imm_q   <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) begin
        ir_q <= bus.Instruction;
      end
      if (state_q == DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
        src_q <= dec_src;
        imm_q <= imm_w;
      end
      cnt_q <= (state_q == MEM && state_d == MEM) ? cnt_q + CW'(1) : '0;
      if (state_d == TRAP && state_q != TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= (state_q == DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
    end
  end

  // Enables are masked by rst so a reset landing mid-MEM cannot write.
  assign bus.pc_write_en = pcw & ~rst;
  assign bus.RegWrite    = reg_write & ~rst;
  assign bus.MemWrite    = mem_write & ~rst;
  assign bus.Branch      = branch & ~rst;
  assign bus.MemToReg    = mem_to_reg & ~rst;
  assign bus.ALUControl  = alu_q;
  assign bus.ALUScr      = src_q;
  assign bus.Imm         = imm_q;
  assign bus.trap        = trap_q;
  assign bus.trap_cause  = cause_q;

`ifdef PERF_CNT_EN
  logic [31:0] retired_q;

  // Counts every PC load; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (bus.pc_write_en) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl. A cycle-indexed
// reference model derived from the instruction latency table predicts every
// control output per cycle relative to FETCH.
module tb_multicycle_ctrl;

  localparam int T = 15;
  localparam int K_R = 0, K_ADDI = 1, K_LD = 2, K_SD = 3, K_BEQ = 4, K_ILL = 5;
  localparam logic [10:0] MASK_ALL   = 11'h7FF;
  localparam logic [10:0] MASK_NOALU = 11'h4F7;

  logic clk;
  logic rst;
  int tests;
  int failures;
  logic [31:0] exp_ret;
  logic [10:0] obs_vec [0:63];
  logic [63:0] obs_imm [0:63];

  multicycle_ctrl_if #(.BITS(64)) bus ();

  multicycle_ctrl #(.BITS(64), .MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec-level decode: class, ALU op, SrcB select and immediate by arithmetic.
  task automatic ref_decode(input logic [31:0] ins, output int kind,
                            output logic [1:0] alu, output logic src, output logic [63:0] imm);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    kind = K_ILL;
    alu = 2'b00;
    src = 1'b0;
    imm = 64'd0;
    if (op == 7'b0110011) begin
      if (f3 == 3'd0 && f7 == 7'd0) begin kind = K_R; alu = 2'b00; end
      else if (f3 == 3'd0 && f7 == 7'b0100000) begin kind = K_R; alu = 2'b01; end
      else if (f3 == 3'd7 && f7 == 7'd0) begin kind = K_R; alu = 2'b10; end
      else if (f3 == 3'd6 && f7 == 7'd0) begin kind = K_R; alu = 2'b11; end
    end else if (op == 7'b0010011 && f3 == 3'd0) begin
      kind = K_ADDI; src = 1'b1;
    end else if (op == 7'b0000011 && f3 == 3'd3) begin
      kind = K_LD; src = 1'b1;
    end else if (op == 7'b0100011 && f3 == 3'd3) begin
      kind = K_SD; src = 1'b1;
    end else if (op == 7'b1100011 && f3 == 3'd0) begin
      kind = K_BEQ; alu = 2'b01;
    end
    if (kind == K_ADDI || kind == K_LD)
      imm = 64'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
    else if (kind == K_SD)
      imm = 64'(ins[31:25]) * 64'd32 + 64'(ins[11:7]) - (ins[31] ? 64'd4096 : 64'd0);
    else if (kind == K_BEQ)
      imm = 64'(ins[7]) * 64'd2048 + 64'(ins[30:25]) * 64'd32 + 64'(ins[11:8]) * 64'd2
            - (ins[31] ? 64'd4096 : 64'd0);
  endtask

  function automatic int model_len(input int kind, input int w);
    case (kind)
      K_R, K_ADDI: return 4;
      K_BEQ:       return 3;
      K_LD:        return (w >= T) ? 4 + T + 3 : 5 + w;
      K_SD:        return (w >= T) ? 4 + T + 3 : 4 + w;
      default:     return 5;
    endcase
  endfunction

  // Expected {pcw, alu[1:0], regw, memw, branch, m2r, src, trap, cause[1:0]} at cycle k after FETCH.
  function automatic logic [10:0] model_vec(input int kind, input logic [1:0] alu,
                                            input logic src, input int w, input int k);
    logic pcw, regw, memw, br, m2r, trp;
    logic [1:0] cause;
    bit to;
    pcw = 0; regw = 0; memw = 0; br = 0; m2r = 0; trp = 0; cause = 2'b00;
    to = (w >= T);
    case (kind)
      K_R, K_ADDI: if (k == 3) begin regw = 1; pcw = 1; end
      K_BEQ:       if (k == 2) begin br = 1; pcw = 1; end
      K_LD: begin
        if (k >= 3 && k <= 3 + (to ? T : w)) m2r = 1;
        if (!to && k == 4 + w) begin regw = 1; pcw = 1; m2r = 1; end
        if (to && k >= 4 + T) begin trp = 1; cause = 2'b10; end
      end
      K_SD: begin
        if (k >= 3 && k < 3 + (to ? T : w + 1)) memw = 1;
        if (!to && k == 3 + w) pcw = 1;
        if (to && k >= 4 + T) begin trp = 1; cause = 2'b10; end
      end
      default: if (k >= 2) begin trp = 1; cause = 2'b01; end
    endcase
    return {pcw, alu, regw, memw, br, m2r, src, trp, cause};
  endfunction

  function automatic logic [31:0] want_ret();
`ifdef PERF_CNT_EN
    return exp_ret;
`else
    return 32'd0;
`endif
  endfunction

  // Runs one instruction from its FETCH cycle for n cycles, recording outputs.
  // mem_ready is random before MEM; from cycle 3 it is high once k >= ready_from.
  task automatic drive_instr(input logic [31:0] ins, input int ready_from, input int n);
    for (int k = 0; k < n; k++) begin
      bus.Instruction = (k == 0) ? ins : $urandom;
      bus.alu_zero = 1'($urandom_range(0, 1));
      if (ready_from < 0 || k < 3) bus.mem_ready = 1'($urandom_range(0, 1));
      else bus.mem_ready = (k >= ready_from);
      #1;
      obs_vec[k] = {bus.pc_write_en, bus.ALUControl, bus.RegWrite, bus.MemWrite, bus.Branch,
                    bus.MemToReg, bus.ALUScr, bus.trap, bus.trap_cause};
      obs_imm[k] = bus.Imm;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Instruction = 32'h0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b1;
    exp_ret = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (({bus.pc_write_en, bus.RegWrite, bus.MemWrite, bus.Branch, bus.MemToReg, bus.trap, bus.trap_cause}) !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got %b want 00000000",
               {bus.pc_write_en, bus.RegWrite, bus.MemWrite, bus.Branch, bus.MemToReg, bus.trap, bus.trap_cause});
    end
    tests++;
    if (bus.retired !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_retired got %0d want 0", bus.retired);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [31:0] prog [4];
    int kind, n, nreg;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    prog = '{32'h00500093, 32'h402081B3, 32'h0020E1B3, 32'h0020F1B3};
    for (int i = 0; i < 4; i++) begin
      ref_decode(prog[i], kind, ralu, rsrc, rimm);
      n = model_len(kind, 0);
      drive_instr(prog[i], -1, n);
      nreg = 0;
      for (int k = 0; k < n; k++) begin
        ev = model_vec(kind, ralu, rsrc, 0, k);
        msk = (k >= 2) ? MASK_ALL : MASK_NOALU;
        if (ev[10]) exp_ret++;
        if (obs_vec[k][7]) nreg++;
        tests++;
        if ((obs_vec[k] & msk) !== (ev & msk)) begin
          failures++;
          $display("[TB] FAIL alu_op%0d cyc%0d ctrl got %b want %b", i, k, obs_vec[k] & msk, ev & msk);
        end
        if (kind == K_ADDI && k >= 2) begin
          tests++;
          if (obs_imm[k] !== rimm) begin
            failures++;
            $display("[TB] FAIL alu_op%0d_imm cyc%0d got %h want %h", i, k, obs_imm[k], rimm);
          end
        end
      end
      tests++;
      if (nreg !== 1) begin
        failures++;
        $display("[TB] FAIL alu_op%0d_regwrite_count got %0d want 1", i, nreg);
      end
      tests++;
      if (bus.retired !== want_ret()) begin
        failures++;
        $display("[TB] FAIL alu_op%0d_retired got %0d want %0d", i, bus.retired, want_ret());
      end
    end
  endtask

  task automatic test_load_wait();
    int kind, n;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    ref_decode(32'h0080B283, kind, ralu, rsrc, rimm);
    n = model_len(kind, 3);
    drive_instr(32'h0080B283, 6, n);
    for (int k = 0; k < n; k++) begin
      ev = model_vec(kind, ralu, rsrc, 3, k);
      msk = (k >= 2) ? MASK_ALL : MASK_NOALU;
      if (ev[10]) exp_ret++;
      tests++;
      if ((obs_vec[k] & msk) !== (ev & msk)) begin
        failures++;
        $display("[TB] FAIL load_wait cyc%0d ctrl got %b want %b", k, obs_vec[k] & msk, ev & msk);
      end
      if (k >= 2) begin
        tests++;
        if (obs_imm[k] !== rimm) begin
          failures++;
          $display("[TB] FAIL load_wait_imm cyc%0d got %h want %h", k, obs_imm[k], rimm);
        end
      end
    end
    tests++;
    if (bus.retired !== want_ret()) begin
      failures++;
      $display("[TB] FAIL load_wait_retired got %0d want %0d", bus.retired, want_ret());
    end
  endtask

  task automatic test_store_timeout();
    int kind, n, nmw;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    ref_decode(32'h0050B823, kind, ralu, rsrc, rimm);
    n = model_len(kind, T);
    drive_instr(32'h0050B823, 1000, n);
    nmw = 0;
    for (int k = 0; k < n; k++) begin
      ev = model_vec(kind, ralu, rsrc, T, k);
      msk = (k >= 2) ? MASK_ALL : MASK_NOALU;
      if (obs_vec[k][6]) nmw++;
      tests++;
      if ((obs_vec[k] & msk) !== (ev & msk)) begin
        failures++;
        $display("[TB] FAIL store_timeout cyc%0d ctrl got %b want %b", k, obs_vec[k] & msk, ev & msk);
      end
      if (k >= 2) begin
        tests++;
        if (obs_imm[k] !== rimm) begin
          failures++;
          $display("[TB] FAIL store_timeout_imm cyc%0d got %h want %h", k, obs_imm[k], rimm);
        end
      end
    end
    tests++;
    if (nmw !== T) begin
      failures++;
      $display("[TB] FAIL store_timeout_memwrite_count got %0d want %0d", nmw, T);
    end
    do_reset();
  endtask

  task automatic test_beq();
    int kind, n;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    for (int r = 0; r < 4; r++) begin
      ref_decode(32'hFE208CE3, kind, ralu, rsrc, rimm);
      n = model_len(kind, 0);
      drive_instr(32'hFE208CE3, -1, n);
      for (int k = 0; k < n; k++) begin
        ev = model_vec(kind, ralu, rsrc, 0, k);
        msk = (k >= 2) ? MASK_ALL : MASK_NOALU;
        if (ev[10]) exp_ret++;
        tests++;
        if ((obs_vec[k] & msk) !== (ev & msk)) begin
          failures++;
          $display("[TB] FAIL beq%0d cyc%0d ctrl got %b want %b", r, k, obs_vec[k] & msk, ev & msk);
        end
      end
      tests++;
      if (obs_imm[2] !== 64'hFFFF_FFFF_FFFF_FFF8) begin
        failures++;
        $display("[TB] FAIL beq%0d_imm got %h want fffffffffffffff8", r, obs_imm[2]);
      end
      tests++;
      if (bus.retired !== want_ret()) begin
        failures++;
        $display("[TB] FAIL beq%0d_retired got %0d want %0d", r, bus.retired, want_ret());
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] prog [3];
    int kind, n;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev;
    prog = '{32'h00000000, 32'h022081B3, 32'h0020A093};
    for (int i = 0; i < 3; i++) begin
      ref_decode(prog[i], kind, ralu, rsrc, rimm);
      n = model_len(kind, 0);
      drive_instr(prog[i], -1, n);
      for (int k = 0; k < n; k++) begin
        ev = model_vec(kind, ralu, rsrc, 0, k);
        tests++;
        if ((obs_vec[k] & MASK_NOALU) !== (ev & MASK_NOALU)) begin
          failures++;
          $display("[TB] FAIL illegal%0d cyc%0d ctrl got %b want %b", i, k, obs_vec[k] & MASK_NOALU, ev & MASK_NOALU);
        end
      end
      do_reset();
    end
  endtask

  task automatic test_reset_mid_mem();
    int kind, n;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    drive_instr(32'h0050B823, 1000, 6);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if ({bus.MemWrite, bus.pc_write_en, bus.RegWrite} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_cycle_enables got %b want 000", {bus.MemWrite, bus.pc_write_en, bus.RegWrite});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    exp_ret = 32'd0;
    #1;
    tests++;
    if ({bus.MemWrite, bus.trap, bus.trap_cause} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL after_reset_mem got %b want 0000", {bus.MemWrite, bus.trap, bus.trap_cause});
    end
    ref_decode(32'h00500093, kind, ralu, rsrc, rimm);
    n = model_len(kind, 0);
    drive_instr(32'h00500093, -1, n);
    for (int k = 0; k < n; k++) begin
      ev = model_vec(kind, ralu, rsrc, 0, k);
      msk = (k >= 2) ? MASK_ALL : MASK_NOALU;
      if (ev[10]) exp_ret++;
      tests++;
      if ((obs_vec[k] & msk) !== (ev & msk)) begin
        failures++;
        $display("[TB] FAIL post_reset_addi cyc%0d ctrl got %b want %b", k, obs_vec[k] & msk, ev & msk);
      end
    end
    tests++;
    if (bus.retired !== want_ret()) begin
      failures++;
      $display("[TB] FAIL post_reset_retired got %0d want %0d", bus.retired, want_ret());
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int kind, n, w, rf, c;
    logic [1:0] ralu;
    logic rsrc;
    logic [63:0] rimm;
    logic [10:0] ev, msk;
    for (int it = 0; it < 40; it++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: begin
          c = int'($urandom_range(0, 3));
          ins[6:0] = 7'b0110011;
          ins[14:12] = (c < 2) ? 3'd0 : ((c == 2) ? 3'd7 : 3'd6);
          ins[31:25] = (c == 1) ? 7'b0100000 : 7'd0;
        end
        1: begin ins[6:0] = 7'b0010011; ins[14:12] = 3'd0; end
        2: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'd3; end
        3: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'd3; end
        4: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd0; end
        5: ins[6:0] = 7'b0010011;
        default: ;
      endcase
      ref_decode(ins, kind, ralu, rsrc, rimm);
      w = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 5));
      if (kind != K_LD && kind != K_SD) w = 0;
      rf = (kind == K_LD || kind == K_SD) ? ((w >= T) ? 1000 : 3 + w) : -1;
      n = model_len(kind, w);
      drive_instr(ins, rf, n);
      for (int k = 0; k < n; k++) begin
        ev = model_vec(kind, ralu, rsrc, w, k);
        msk = (k >= 2 && kind != K_ILL) ? MASK_ALL : MASK_NOALU;
        if (ev[10]) exp_ret++;
        tests++;
        if ((obs_vec[k] & msk) !== (ev & msk)) begin
          failures++;
          $display("[TB] FAIL rand%0d ins=%h cyc%0d ctrl got %b want %b", it, ins, k, obs_vec[k] & msk, ev & msk);
        end
        if (k >= 2 && kind != K_ILL && kind != K_R) begin
          tests++;
          if (obs_imm[k] !== rimm) begin
            failures++;
            $display("[TB] FAIL rand%0d_imm ins=%h cyc%0d got %h want %h", it, ins, k, obs_imm[k], rimm);
          end
        end
      end
      tests++;
      if (bus.retired !== want_ret()) begin
        failures++;
        $display("[TB] FAIL rand%0d_retired got %0d want %0d", it, bus.retired, want_ret());
      end
      if (kind == K_ILL || w >= T) do_reset();
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_store_timeout();
    test_beq();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 64-bit RISC-V datapath.
- Decodes the 32-bit instruction word and drives ALUControl, RegWrite, MemWrite, Branch, MemToReg, ALUScr, Imm and a PC write enable.
- Drives each control through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Stretches the MEM phase until data memory handshakes ready and traps illegal opcodes.
- Sits beside the datapath top and replaces the free-running PC write.

Parameters:
BITS, 64, datapath/immediate width.
MEM_TIMEOUT, 15, max MEM wait cycles before a bus-error trap (counter width $clog2(MEM_TIMEOUT+1)).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
Instruction  input  32  current instruction word from instruction memory.
alu_zero  input  1  ALUFlags[0] (zero flag) from the ALU.
mem_ready  input  1  data memory completes the current access this cycle.
pc_write_en  output  1  PC register load enable.
ALUControl  output  2  00 add, 01 sub, 10 and, 11 or.
RegWrite  output  1  register file write enable.
MemWrite  output  1  data memory write enable.
Branch  output  1  branch-target select qualifier (ANDed with zero in the datapath).
MemToReg  output  1  write-back select: 1 = memory, 0 = ALU.
ALUScr  output  1  SrcB select: 1 = Imm, 0 = register.
Imm  output  BITS  sign-extended immediate.
trap  output  1  sticky error indication.
trap_cause  output  2  00 none, 01 illegal opcode/funct, 10 memory timeout.
retired  output  32  retired-instruction count (feature-dependent).

Behaviour:
- Reset (rst=1 at a clock edge): state=FETCH; instruction register, timeout counter, trap, trap_cause and retired all 0. All enables are 0 while in reset.
- FETCH: latch Instruction into the internal IR; go to DECODE. All enables 0.
- DECODE: decode the IR; register Imm and the op class.
  - Legal ops go to EXEC.
  - Anything else goes to TRAP: trap_cause=01.
- Supported ops and their decode:
  - R-type (op 0110011), ALUScr=0:
    - funct3=000, funct7=0000000 -> add
    - funct3=000, funct7=0100000 -> sub
    - funct3=111, funct7=0000000 -> and
    - funct3=110, funct7=0000000 -> or
  - addi (op 0010011, f3=000): add, ALUScr=1, I-immediate.
  - ld (op 0000011, f3=011): add, ALUScr=1, I-immediate.
  - sd (op 0100011, f3=011): add, ALUScr=1, S-immediate.
  - beq (op 1100011, f3=000): sub, ALUScr=0, B-immediate with bit0=0.
- EXEC: ALUControl/ALUScr held from DECODE through the end of the instruction.
  - R/addi -> WB.
  - ld/sd -> MEM.
  - beq: Branch=1 and pc_write_en=1 for exactly this cycle, then FETCH.
- MEM:
  - sd: MemWrite=1 every cycle in MEM until the mem_ready cycle inclusive. On mem_ready: pc_write_en=1 and go to FETCH.
  - ld: MemToReg=1. On mem_ready go to WB.
  - The timeout counter increments each non-ready cycle. Reaching MEM_TIMEOUT -> TRAP with cause 10; MemWrite drops that cycle.
  - mem_ready=1 on the first MEM cycle gives zero wait.
- WB: RegWrite=1 and pc_write_en=1 for one cycle. MemToReg=1 for ld, 0 otherwise. Then FETCH.
- TRAP: absorbing; all enables 0; trap=1. Only rst exits.
- Reset arriving in any state, including mid-MEM, aborts immediately. No write enable is asserted in the reset cycle.
- Latency without waits, FETCH to next FETCH:
  - R/addi 4 cycles
  - ld 5 cycles
  - sd 4 cycles
  - beq 3 cycles
- Each memory wait cycle adds 1.
- Control outputs are fully registered/state-decoded with no combinational path from mem_ready to any output except pc_write_en (sd) and MemWrite deassert timing. Imm is stable from EXEC onward.

Optional Feature:
PERF_CNT_EN.
- Defined: retired is a 32-bit counter. It increments on every cycle with pc_write_en=1, wraps 0xFFFFFFFF->0, and clears on rst.
- Undefined: retired is tied to 0 and no counter flops exist.

Decomposition:
- Package ctrl_pkg holds:
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALU control encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - trap cause codes
- One sub-module, imm_gen: purely combinational I/S/B immediate extraction and sign extension to BITS.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> EXEC: ALUControl=00, ALUScr=1, Imm=5. WB: RegWrite=1, pc_write_en=1. 4 cycles total.
- sub x3,x1,x2 (0x402081B3) -> ALUControl=01, ALUScr=0. Then or (funct3=110) -> ALUControl=11. Each asserts RegWrite for exactly one cycle.
- ld x5,8(x1) (0x0080B283), mem_ready low 3 cycles -> MEM held 4 cycles, then WB with MemToReg=1, RegWrite=1. 8 cycles total. retired +1 with PERF_CNT_EN.
- sd x5,16(x1) (0x0050B823), mem_ready never -> MemWrite high for 15 cycles, then trap=1, trap_cause=10. Outputs stay 0 until rst.
- beq x1,x2,-8 (0xFE208CE3) -> Imm=0xFFFFFFFFFFFFFFF8. EXEC: Branch=1 and pc_write_en=1 for one cycle, independent of alu_zero. 3 cycles total.
- Instruction 0x00000000 -> TRAP at DECODE, cause 01. rst pulse mid-MEM of a store -> next cycle state FETCH, MemWrite=0, trap=0.
